i_buf_controller: RTL and testbench
===================================

Name: i_buf_controller

Overview:
Capture-side counterpart of the video output controller. It receives a raw 8-bit pixel stream with vsync/hsync/vde from the camera/video front end and packs 4 pixels per 32-bit word. Each word is written into the capture linebuffer, and the block notifies the Processing System (PS) when a line is complete and when a new frame starts. The PS then copies each finished line from the linebuffer to the framebuffer.

Parameters:
ADDRESS_WIDTH, 32, linebuffer word-address width.
DISPLAY_WIDTH, 640, active pixels per line; must be >= 4 and less than 2^13.
DISPLAY_HEIGHT, 320, active lines per frame; must be less than 2^13.

Ports:
pclk  input  1  video pixel clock
reset_n  input  1  synchronous reset, active-low
vsync  input  1  vertical sync, active-low
hsync  input  1  horizontal sync, active-low; informational only, line framing uses vde
vde  input  1  video data enable
i_data  input  8  RAW pixel value
addr  output  ADDRESS_WIDTH  linebuffer word address
o_data  output  32  packed word; first pixel of each group in [31:24]
we  output  1  linebuffer write strobe, one cycle per word
line_ready  output  1  one-cycle pulse: a line is complete in the linebuffer
frame_start  output  1  one-cycle pulse: a new frame has begun
line_count  output  13  index of the line currently being captured (0-based)
overflow  output  1  sticky flag: excess pixels or lines were dropped

Behaviour:
- Reset (synchronous, active-low; clock pclk): addr=0, o_data=0, we=0, line_ready=0, frame_start=0, line_count=0, overflow=0. Pack register, lane counter, pixel counter and sync history are cleared. FSM goes to WAIT_FRAME.
- Input stage: vsync, vde and i_data are registered once. Edge detection operates on the registered copies.
- Frame start = falling edge of registered vsync.
  - frame_start pulses in the cycle after the edge is detected.
  - At the same time: line_count=0, addr=0, lane=0, overflow cleared. FSM goes to WAIT_LINE.
- FSM states:
  - WAIT_FRAME: ignore vde; leave on frame start only.
  - WAIT_LINE: on registered vde=1, go to ACTIVE and capture that pixel as lane 0.
  - ACTIVE: for each registered-vde=1 cycle, shift the pixel into the pack register and increment lane (mod 4). When lane 3 is captured, the next cycle has we=1, o_data = 4 pixels (oldest in [31:24]) and addr = word index. addr increments the cycle after each write. On registered vde falling, go to FLUSH.
  - FLUSH:
    - If lane != 0, write the partial word left-justified and zero-padded (we=1, one cycle).
    - line_ready pulses exactly one cycle after the final write, or immediately if no partial word remains.
    - line_count increments in the same cycle as line_ready. addr returns to 0.
    - If line_count reaches DISPLAY_HEIGHT, go to WAIT_FRAME; otherwise go to WAIT_LINE.
- Latency: a pixel presented with vde=1 before edge N completes a word whose we is high in the cycle following edge N+2.
- Long line: pixels beyond DISPLAY_WIDTH are dropped (no write) and overflow is set.
- Short line: ceil(n/4) words are written; line_ready is still issued.
- Excess lines: vde during WAIT_FRAME after DISPLAY_HEIGHT lines is ignored and sets overflow.
- vsync edge in ACTIVE or FLUSH: abort the line. Suppress any pending write and line_ready. Frame-start actions take priority.
- frame_start and line_ready never assert in the same cycle. we never asserts outside ACTIVE or FLUSH.
- Reset asserted mid-line: all outputs return to reset values on the next edge, and no write is issued.

Optional Feature:
I_BUF_PINGPONG_EN
- Defined: addr bit ADDRESS_WIDTH-1 is a bank bit; the word index occupies the lower bits.
  - The bank toggles on each line_ready and is reset to 0 on frame start.
  - An extra output line_bank (1 bit) holds the bank of the most recently completed line, valid with and after line_ready. The PS reads that bank while the other is being filled.
- Undefined: addr bit ADDRESS_WIDTH-1 behaves as a normal address bit, all lines use word addresses from 0 upwards, and the line_bank port does not exist.

Test Plan:
- DISPLAY_WIDTH=8, DISPLAY_HEIGHT=2: vsync fall, then two lines of pixels 0x01..0x08 -> frame_start once; per line we twice: addr0=0x01020304, addr1=0x05060708; line_ready after second write; line_count 0->1->2.
- Line of 6 pixels 0xA0..0xA5 -> words 0xA0A1A2A3 and 0xA4A50000; line_ready; overflow=0.
- Line of 10 pixels (width 8) -> exactly 2 writes; overflow=1 until next frame_start clears it.
- vsync fall after 3 pixels of a line -> no we, no line_ready; frame_start; next line writes from addr 0.
- vde pulses before the first vsync edge after reset, and reset_n=0 mid-line -> no we; all outputs at reset values.
- I_BUF_PINGPONG_EN, ADDRESS_WIDTH=10: two lines -> line 0 writes addr 0x000/0x001, line 1 writes addr 0x200/0x201; line_bank reads 0 then 1.

Source files
------------

// File: rtl/i_buf_if.sv
// Capture-side video/linebuffer bundle for i_buf_controller.
//   Video in : vsync (active-low), hsync (active-low, informational), vde, i_data[7:0]
//   Buffer out: addr, o_data[31:0], we
//   PS status: line_ready, frame_start, line_count[12:0], overflow
//   line_bank exists only when I_BUF_PINGPONG_EN is defined.
// The controller uses the master modport; the video source / linebuffer / PS side uses slave.
interface i_buf_if #(
  parameter int unsigned ADDRESS_WIDTH = 32
);
  logic                     vsync;
  logic                     hsync;
  logic                     vde;
  logic [7:0]               i_data;
  logic [ADDRESS_WIDTH-1:0] addr;
  logic [31:0]              o_data;
  logic                     we;
  logic                     line_ready;
  logic                     frame_start;
  logic [12:0]              line_count;
  logic                     overflow;
`ifdef I_BUF_PINGPONG_EN
  logic                     line_bank;
`endif

  modport master (
    input  vsync, hsync, vde, i_data,
    output addr, o_data, we, line_ready, frame_start, line_count, overflow
`ifdef I_BUF_PINGPONG_EN
    , output line_bank
`endif
  );

  modport slave (
    output vsync, hsync, vde, i_data,
    input  addr, o_data, we, line_ready, frame_start, line_count, overflow
`ifdef I_BUF_PINGPONG_EN
    , input line_bank
`endif
  );
endinterface

// File: rtl/i_buf_controller.sv
// Capture linebuffer controller: packs a raw 8-bit pixel stream into 32-bit words
// (first pixel in [31:24]), writes them to the linebuffer and tells the PS when a
// line is complete and when a new frame begins.
//
// Ports:
//   pclk    - pixel clock
//   reset_n - synchronous reset, active-low
//   bus     - i_buf_if.master: vsync/hsync/vde/i_data in; addr/o_data/we,
//             line_ready/frame_start pulses, line_count, sticky overflow out.
//
// Build option: define I_BUF_PINGPONG_EN to make addr[ADDRESS_WIDTH-1] a bank bit that
// toggles per completed line, and to add the line_bank output.
module i_buf_controller #(
  parameter int unsigned ADDRESS_WIDTH  = 32,
  parameter int unsigned DISPLAY_WIDTH  = 640,
  parameter int unsigned DISPLAY_HEIGHT = 320
) (
  input logic     pclk,
  input logic     reset_n,
  i_buf_if.master bus
);

`ifdef I_BUF_PINGPONG_EN
  localparam int unsigned IdxW = ADDRESS_WIDTH - 1;
`else
  localparam int unsigned IdxW = ADDRESS_WIDTH;
`endif
  localparam logic [12:0] WidthLim  = 13'(DISPLAY_WIDTH);
  localparam logic [12:0] HeightLim = 13'(DISPLAY_HEIGHT);

  typedef enum logic [1:0] {StWaitFrame, StWaitLine, StActive, StFlush} state_e;

  state_e state_q, state_d;

  logic        vsync_q, vsync_qq, vde_q;
  logic [7:0]  data_q;
  logic [1:0]  lane_q, lane_d;
  logic [12:0] pix_q, pix_d;
  logic [31:0] pack_q, pack_d;
  logic        full_q, full_d;
  logic [IdxW-1:0] word_q, word_d;
  logic [31:0] o_data_q, o_data_d;
  logic        we_q, we_d;
  logic        line_ready_q, line_ready_d;
  logic        frame_start_q, frame_start_d;
  logic [12:0] line_count_q, line_count_d;
  logic        overflow_q, overflow_d;
  logic        capture;
  logic        vs_fall;
`ifdef I_BUF_PINGPONG_EN
  logic        bank_q, bank_d;
  logic        line_bank_q, line_bank_d;
`endif

  logic unused_hsync;
  assign unused_hsync = bus.hsync;

  assign vs_fall = vsync_qq & ~vsync_q;

  always_comb begin
    state_d       = state_q;
    lane_d        = lane_q;
    pix_d         = pix_q;
    pack_d        = pack_q;
    full_d        = 1'b0;
    word_d        = we_q ? word_q + IdxW'(1) : word_q;
    o_data_d      = o_data_q;
    we_d          = 1'b0;
    line_ready_d  = 1'b0;
    frame_start_d = 1'b0;
    line_count_d  = line_count_q;
    overflow_d    = overflow_q;
    capture       = 1'b0;
`ifdef I_BUF_PINGPONG_EN
    bank_d        = bank_q;
    line_bank_d   = line_bank_q;
`endif

    // A word completed on the previous edge is written one cycle later.
    if (full_q) begin
      we_d     = 1'b1;
      o_data_d = pack_q;
    end

    unique case (state_q)
      StWaitFrame: begin
        if (vde_q && (line_count_q == HeightLim)) overflow_d = 1'b1;
      end
      StWaitLine: begin
        if (vde_q) begin
          capture = 1'b1;
          state_d = StActive;
        end
      end
      StActive: begin
        if (vde_q) capture = 1'b1;
        else       state_d = StFlush;
      end
      StFlush: begin
        if (lane_q != 2'd0) begin
          // Partial word: left-justify the captured lanes, zero-pad the rest.
          we_d = 1'b1;
          unique case (lane_q)
            2'd1:    o_data_d = {pack_q[7:0], 24'h0};
            2'd2:    o_data_d = {pack_q[15:0], 16'h0};
            default: o_data_d = {pack_q[23:0], 8'h0};
          endcase
          lane_d = 2'd0;
        end else begin
          line_ready_d = 1'b1;
          line_count_d = line_count_q + 13'd1;
          word_d       = '0;
          pix_d        = '0;
`ifdef I_BUF_PINGPONG_EN
          line_bank_d  = bank_q;
          bank_d       = ~bank_q;
`endif
          state_d = (line_count_d == HeightLim) ? StWaitFrame : StWaitLine;
        end
      end
      default: state_d = StWaitFrame;
    endcase

    if (capture) begin
      if (pix_q < WidthLim) begin
        pack_d = {pack_q[23:0], data_q};
        lane_d = lane_q + 2'd1;
        pix_d  = pix_q + 13'd1;
        full_d = (lane_q == 2'd3);
      end else begin
        overflow_d = 1'b1;
      end
    end

    // Frame start overrides everything, including an in-flight line.
    if (vs_fall) begin
      state_d       = StWaitLine;
      frame_start_d = 1'b1;
      line_count_d  = '0;
      word_d        = '0;
      lane_d        = '0;
      pix_d         = '0;
      full_d        = 1'b0;
      overflow_d    = 1'b0;
      we_d          = 1'b0;
      line_ready_d  = 1'b0;
      o_data_d      = o_data_q;
`ifdef I_BUF_PINGPONG_EN
      bank_d        = 1'b0;
`endif
    end
  end

  always_ff @(posedge pclk) begin
    if (!reset_n) begin
      state_q       <= StWaitFrame;
      vsync_q       <= 1'b0;
      vsync_qq      <= 1'b0;
      vde_q         <= 1'b0;
      data_q        <= '0;
      lane_q        <= '0;
      pix_q         <= '0;
      pack_q        <= '0;
      full_q        <= 1'b0;
      word_q        <= '0;
      o_data_q      <= '0;
      we_q          <= 1'b0;
      line_ready_q  <= 1'b0;
      frame_start_q <= 1'b0;
      line_count_q  <= '0;
      overflow_q    <= 1'b0;
`ifdef I_BUF_PINGPONG_EN
      bank_q        <= 1'b0;
      line_bank_q   <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      vsync_q       <= bus.vsync;
      vsync_qq      <= vsync_q;
      vde_q         <= bus.vde;
      data_q        <= bus.i_data;
      lane_q        <= lane_d;
      pix_q         <= pix_d;
      pack_q        <= pack_d;
      full_q        <= full_d;
      word_q        <= word_d;
      o_data_q      <= o_data_d;
      we_q          <= we_d;
      line_ready_q  <= line_ready_d;
      frame_start_q <= frame_start_d;
      line_count_q  <= line_count_d;
      overflow_q    <= overflow_d;
`ifdef I_BUF_PINGPONG_EN
      bank_q        <= bank_d;
      line_bank_q   <= line_bank_d;
`endif
    end
  end

`ifdef I_BUF_PINGPONG_EN
  assign bus.addr      = {bank_q, word_q};
  assign bus.line_bank = line_bank_q;
`else
  assign bus.addr      = word_q;
`endif
  assign bus.o_data      = o_data_q;
  assign bus.we          = we_q;
  assign bus.line_ready  = line_ready_q;
  assign bus.frame_start = frame_start_q;
  assign bus.line_count  = line_count_q;
  assign bus.overflow    = overflow_q;

endmodule

// File: tb/tb_i_buf_controller.sv
// Bench for i_buf_controller (width 8, height 2): table vectors, hand-written
// corner sequences and randomized lines against a packing model.
module tb_i_buf_controller;
  localparam int unsigned AW = 10;
  localparam int unsigned W  = 8;
  localparam int unsigned H  = 2;
`ifdef I_BUF_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif

  logic pclk = 1'b0;
  logic reset_n = 1'b0;
  always #5 pclk = ~pclk;

  i_buf_if #(.ADDRESS_WIDTH(AW)) bus ();

  i_buf_controller #(
    .ADDRESS_WIDTH (AW),
    .DISPLAY_WIDTH (W),
    .DISPLAY_HEIGHT(H)
  ) dut (
    .pclk   (pclk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    int unsigned npix;
    logic [7:0]  base;
    int unsigned nwr;
    logic [31:0] w_first;
    logic [31:0] w_last;
    logic        ovf;
  } vec_t;

  vec_t vecs[6];

  int unsigned n_checks = 0;
  int unsigned n_fail = 0;
  int unsigned cyc_n = 0;
  int unsigned lr_cnt = 0, fs_cnt = 0, overlap = 0;
  int unsigned first_we_cyc = 0, last_we_cyc = 0, lr_cyc = 0, fs_cyc = 0, p3_cyc = 0;
  logic [AW-1:0] wa[$];
  logic [31:0]   wd[$];
  logic          lbq[$];
  logic [7:0]    pix[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // Advance one clock and record output events #1 after the edge.
  task automatic cyc();
    @(posedge pclk);
    cyc_n++;
    #1;
    if (bus.we === 1'b1) begin
      if (wa.size() == 0) first_we_cyc = cyc_n;
      wa.push_back(bus.addr);
      wd.push_back(bus.o_data);
      last_we_cyc = cyc_n;
    end
    if (bus.line_ready === 1'b1) begin
      lr_cnt++;
      lr_cyc = cyc_n;
`ifdef I_BUF_PINGPONG_EN
      lbq.push_back(bus.line_bank);
`endif
    end
    if (bus.frame_start === 1'b1) begin
      fs_cnt++;
      fs_cyc = cyc_n;
    end
    if (bus.frame_start === 1'b1 && bus.line_ready === 1'b1) overlap++;
  endtask

  task automatic idle(input int unsigned n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic frame_sync(output int unsigned drive_cyc);
    drive_cyc = cyc_n;
    bus.vsync = 1'b0;
    cyc();
    cyc();
    bus.vsync = 1'b1;
    idle(3);
  endtask

  task automatic fill_seq(input int unsigned n, input logic [7:0] base);
    pix.delete();
    for (int i = 0; i < n; i++) pix.push_back(base + 8'(i));
  endtask

  task automatic send_line(input int unsigned n);
    for (int i = 0; i < n; i++) begin
      bus.vde    = 1'b1;
      bus.i_data = pix[i];
      if (i == 3) p3_cyc = cyc_n;
      cyc();
    end
    bus.vde    = 1'b0;
    bus.i_data = 8'h00;
    idle(8);
  endtask

  // Model: the first min(n, W) pixels packed four per word, oldest in the MSB byte,
  // a short tail zero-padded; line li of a frame sits in bank li%2 when banking is on.
  task automatic expect_line(input string tag, input int unsigned li, input int unsigned n);
    int unsigned m, nw;
    logic [31:0] e;
    logic [AW-1:0] ea;
    m  = (n > W) ? W : n;
    nw = (m + 3) / 4;
    check({tag, "_nwr"}, 64'(wa.size()), 64'(nw));
    for (int k = 0; k < nw && k < wa.size(); k++) begin
      e = 32'h0;
      for (int b = 0; b < 4; b++)
        if (4 * k + b < m) e = e | (32'(pix[4 * k + b]) << (24 - 8 * b));
      ea = AW'(k);
      if (PP && (li % 2 == 1)) ea = ea | (AW'(1) << (AW - 1));
      check({tag, "_addr"}, 64'(wa[k]), 64'(ea));
      check({tag, "_data"}, 64'(wd[k]), 64'(e));
    end
    wa.delete();
    wd.delete();
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_addr"}, 64'(bus.addr), 64'h0);
    check({tag, "_odata"}, 64'(bus.o_data), 64'h0);
    check({tag, "_we"}, 64'(bus.we), 64'h0);
    check({tag, "_lr"}, 64'(bus.line_ready), 64'h0);
    check({tag, "_fs"}, 64'(bus.frame_start), 64'h0);
    check({tag, "_lc"}, 64'(bus.line_count), 64'h0);
    check({tag, "_ovf"}, 64'(bus.overflow), 64'h0);
  endtask

  initial begin
    int unsigned dc, lr0, fs0, n0, n1;
    bit ovf_exp;

    vecs[0] = '{8,  8'h01, 2, 32'h01020304, 32'h05060708, 1'b0};
    vecs[1] = '{6,  8'hA0, 2, 32'hA0A1A2A3, 32'hA4A50000, 1'b0};
    vecs[2] = '{10, 8'h10, 2, 32'h10111213, 32'h14151617, 1'b1};
    vecs[3] = '{3,  8'h30, 1, 32'h30313200, 32'h30313200, 1'b0};
    vecs[4] = '{4,  8'hC0, 1, 32'hC0C1C2C3, 32'hC0C1C2C3, 1'b0};
    vecs[5] = '{5,  8'hE0, 2, 32'hE0E1E2E3, 32'hE4000000, 1'b0};

    bus.vsync  = 1'b1;
    bus.hsync  = 1'b1;
    bus.vde    = 1'b0;
    bus.i_data = 8'h00;

    // Reset state.
    idle(3);
    check_reset_outputs("reset");
    reset_n = 1'b1;
    idle(2);

    // vde before any frame start is ignored.
    fill_seq(6, 8'h55);
    send_line(6);
    check("prevs_nwr", 64'(wa.size()), 64'd0);
    check("prevs_lr", 64'(lr_cnt), 64'd0);
    check("prevs_ovf", 64'(bus.overflow), 64'd0);

    // Full frame: two lines of 0x01..0x08.
    frame_sync(dc);
    check("main_fs_cnt", 64'(fs_cnt), 64'd1);
    check("main_fs_cyc", 64'(fs_cyc), 64'(dc + 2));
    fill_seq(8, 8'h01);
    send_line(8);
    check("main_latency", 64'(first_we_cyc), 64'(p3_cyc + 3));
    check("main_lr_after_we", 64'(lr_cyc), 64'(last_we_cyc + 1));
    check("main_lc1", 64'(bus.line_count), 64'd1);
    expect_line("main_l0", 0, 8);
    send_line(8);
    check("main_lc2", 64'(bus.line_count), 64'd2);
    check("main_lr_cnt", 64'(lr_cnt), 64'd2);
    expect_line("main_l1", 1, 8);
`ifdef I_BUF_PINGPONG_EN
    check("bank_n", 64'(lbq.size()), 64'd2);
    if (lbq.size() == 2) begin
      check("bank_l0", 64'(lbq[0]), 64'd0);
      check("bank_l1", 64'(lbq[1]), 64'd1);
    end
`endif

    // Excess line after the frame is complete.
    send_line(4);
    check("excess_nwr", 64'(wa.size()), 64'd0);
    check("excess_lr", 64'(lr_cnt), 64'd2);
    check("excess_ovf", 64'(bus.overflow), 64'd1);

    // Table vectors, one line per fresh frame.
    for (int v = 0; v < 6; v++) begin
      frame_sync(dc);
      check("vec_ovf_clr", 64'(bus.overflow), 64'd0);
      check("vec_lc0", 64'(bus.line_count), 64'd0);
      lr0 = lr_cnt;
      fill_seq(vecs[v].npix, vecs[v].base);
      send_line(vecs[v].npix);
      check("vec_nwr", 64'(wa.size()), 64'(vecs[v].nwr));
      if (wd.size() > 0) begin
        check("vec_first", 64'(wd[0]), 64'(vecs[v].w_first));
        check("vec_last", 64'(wd[wd.size() - 1]), 64'(vecs[v].w_last));
        check("vec_last_addr", 64'(wa[wa.size() - 1]), 64'(vecs[v].nwr - 1));
      end
      check("vec_ovf", 64'(bus.overflow), 64'(vecs[v].ovf));
      check("vec_lr", 64'(lr_cnt - lr0), 64'd1);
      check("vec_lc1", 64'(bus.line_count), 64'd1);
      if (!vecs[v].ovf) check("vec_lr_timing", 64'(lr_cyc), 64'(last_we_cyc + 1));
      wa.delete();
      wd.delete();
    end

    // vsync falls while a 3-pixel partial word is waiting to be flushed.
    frame_sync(dc);
    lr0 = lr_cnt;
    fs0 = fs_cnt;
    fill_seq(3, 8'h70);
    for (int i = 0; i < 3; i++) begin
      bus.vde    = 1'b1;
      bus.i_data = pix[i];
      cyc();
    end
    bus.vde    = 1'b0;
    bus.i_data = 8'h00;
    cyc();
    bus.vsync = 1'b0;
    cyc();
    cyc();
    bus.vsync = 1'b1;
    idle(6);
    check("abort_nwr", 64'(wa.size()), 64'd0);
    check("abort_lr", 64'(lr_cnt - lr0), 64'd0);
    check("abort_fs", 64'(fs_cnt - fs0), 64'd1);
    fill_seq(8, 8'h81);
    send_line(8);
    expect_line("abort_next", 0, 8);

    // Reset in the middle of the second line, with a full word about to be written.
    frame_sync(dc);
    fill_seq(8, 8'h90);
    send_line(8);
    expect_line("rst_l0", 0, 8);
    lr0 = lr_cnt;
    fill_seq(6, 8'hB0);
    for (int i = 0; i < 4; i++) begin
      bus.vde    = 1'b1;
      bus.i_data = pix[i];
      cyc();
    end
    reset_n = 1'b0;
    bus.i_data = pix[4];
    cyc();
    check_reset_outputs("midrst");
    cyc();
    cyc();
    bus.vde = 1'b0;
    reset_n = 1'b1;
    idle(6);
    check("midrst_nwr", 64'(wa.size()), 64'd0);
    check("midrst_lr", 64'(lr_cnt - lr0), 64'd0);
    check("midrst_lc", 64'(bus.line_count), 64'd0);

    // Randomized frames of two lines each.
    for (int f = 0; f < 20; f++) begin
      frame_sync(dc);
      lr0 = lr_cnt;
      n0 = $urandom_range(12, 1);
      n1 = $urandom_range(12, 1);
      pix.delete();
      for (int i = 0; i < n0; i++) pix.push_back(8'($urandom));
      send_line(n0);
      expect_line("rnd_l0", 0, n0);
      ovf_exp = (n0 > W);
      check("rnd_ovf0", 64'(bus.overflow), 64'(ovf_exp));
      check("rnd_lc0", 64'(bus.line_count), 64'd1);
      pix.delete();
      for (int i = 0; i < n1; i++) pix.push_back(8'($urandom));
      send_line(n1);
      expect_line("rnd_l1", 1, n1);
      ovf_exp = ovf_exp || (n1 > W);
      check("rnd_ovf1", 64'(bus.overflow), 64'(ovf_exp));
      check("rnd_lc1", 64'(bus.line_count), 64'd2);
      check("rnd_lr", 64'(lr_cnt - lr0), 64'd2);
    end

    check("fs_lr_overlap", 64'(overlap), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
